// File: rtl/cordic_buf_pkg.sv
// Shared defaults and helpers for the CORDIC stream buffer.
package cordic_buf_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH_IN  = 4;
  localparam int DEF_DEPTH_OUT = 4;

  // Wide enough for any DATA_W in use; sliced down to the word width by users.
  localparam logic [63:0] DATA_RST = '0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cordic_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty derive from the registered count and
// the head output holds the last popped word while the FIFO is empty.
module cordic_sync_fifo
  import cordic_buf_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH_IN
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [WIDTH-1:0]            wr_data_i,
  input  logic                        rd_en_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o,
  output logic                        full_o,
  output logic                        empty_o
);

  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = DEPTH[CW-1:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] last_q;
  logic             wr_acc, rd_acc;

  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // A push while full is dropped even if a pop frees a slot this same cycle.
  assign wr_acc  = wr_en_i && !full_o;
  assign rd_acc  = rd_en_i && !empty_o;

  assign rd_data_o = empty_o ? last_q : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
    else if (!wr_acc && rd_acc) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= WIDTH'(DATA_RST);
    end else begin
      count_q <= count_d;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_acc) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        last_q   <= mem_q[rd_ptr_q];
      end
    end
  end

  // NOTE: storage is not reset; the count gates every read so stale contents are never visible.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/cordic_stream_buffer.sv
// Decoupling buffer between the AHB-Lite CORDIC bridge and the CORDIC core, with
// credit-based issue. Optional sticky drop flag: CORDIC_BUF_OVF_FLAG_EN.
module cordic_stream_buffer
  import cordic_buf_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH_IN  = DEF_DEPTH_IN,
  parameter int DEPTH_OUT = DEF_DEPTH_OUT
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [DATA_W-1:0] in_interface,
  input  logic              valid_in_interface,
  output logic              in_full,
  output logic [DATA_W-1:0] out_interface,
  output logic              valid_out_interface,
  input  logic              rd_pop,
  output logic              empty,
  output logic              busy,
  output logic [DATA_W-1:0] core_in_data,
  output logic              core_in_valid,
  input  logic              core_in_ready,
  input  logic [DATA_W-1:0] core_out_data,
  input  logic              core_out_valid,
  output logic              overflow
);

  localparam int ICW = clog2(DEPTH_IN + 1);
  localparam int OCW = clog2(DEPTH_OUT + 1);
  localparam logic [OCW:0] CREDIT_MAX = DEPTH_OUT[OCW:0];

  logic [ICW-1:0] in_count;
  logic           in_empty;
  logic [OCW-1:0] out_count;
  logic           out_full;
  logic [OCW-1:0] inflight_q, inflight_d;
  logic [OCW:0]   credit_sum;
  logic           issue, ret;

  cordic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH_IN)) u_in_fifo (
    .clk_i(HCLK), .rst_i(HRESET),
    .wr_en_i(valid_in_interface), .wr_data_i(in_interface),
    .rd_en_i(issue), .rd_data_o(core_in_data),
    .count_o(in_count), .full_o(in_full), .empty_o(in_empty)
  );

  cordic_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH_OUT)) u_out_fifo (
    .clk_i(HCLK), .rst_i(HRESET),
    .wr_en_i(ret), .wr_data_i(core_out_data),
    .rd_en_i(rd_pop), .rd_data_o(out_interface),
    .count_o(out_count), .full_o(out_full), .empty_o(empty)
  );

  // Every issued word must already own an output slot: the core cannot be stalled.
  assign credit_sum    = {1'b0, inflight_q} + {1'b0, out_count};
  assign core_in_valid = !in_empty && (credit_sum < CREDIT_MAX);
  assign issue         = core_in_valid && core_in_ready;
  // Results with no matching credit (stale after reset) are discarded.
  assign ret           = core_out_valid && (inflight_q != '0) && !out_full;

  assign valid_out_interface = !empty;
  assign busy                = (in_count != '0) || (inflight_q != '0);

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !ret)      inflight_d = inflight_q + OCW'(1);
    else if (!issue && ret) inflight_d = inflight_q - OCW'(1);
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) inflight_q <= '0;
    else        inflight_q <= inflight_d;
  end

`ifdef CORDIC_BUF_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  assign ovf_d = ovf_q || (valid_in_interface && in_full) || (core_out_valid && !ret);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_stream_buffer.sv
// Directed self-checking bench for cordic_stream_buffer (default parameters).
module tb_cordic_stream_buffer;

`ifdef CORDIC_BUF_OVF_FLAG_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] in_interface;
  logic        valid_in_interface;
  logic        in_full;
  logic [31:0] out_interface;
  logic        valid_out_interface;
  logic        rd_pop;
  logic        empty;
  logic        busy;
  logic [31:0] core_in_data;
  logic        core_in_valid;
  logic        core_in_ready;
  logic [31:0] core_out_data;
  logic        core_out_valid;
  logic        overflow;

  int vectors     = 0;
  int miscompares = 0;

  cordic_stream_buffer dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .in_interface(in_interface), .valid_in_interface(valid_in_interface),
    .in_full(in_full), .out_interface(out_interface),
    .valid_out_interface(valid_out_interface), .rd_pop(rd_pop),
    .empty(empty), .busy(busy),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid),
    .core_in_ready(core_in_ready), .core_out_data(core_out_data),
    .core_out_valid(core_out_valid), .overflow(overflow)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic apply_reset();
    HRESET = 1'b1;
    #1;
    tick();
    HRESET = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    HRESET = 1'b1; in_interface = '0; valid_in_interface = 1'b0; rd_pop = 1'b0;
    core_in_ready = 1'b0; core_out_data = '0; core_out_valid = 1'b0;
    #1;
    tick(); tick();
    HRESET = 1'b0;
    tick();
    vectors++; if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
    vectors++; if (valid_out_interface !== 1'b0) begin miscompares++; $display("FAIL reset_valid_out: got %b want 0", valid_out_interface); end
    vectors++; if (core_in_valid !== 1'b0) begin miscompares++; $display("FAIL reset_core_in_valid: got %b want 0", core_in_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (out_interface !== 32'h0) begin miscompares++; $display("FAIL reset_out_interface: got %h want 0", out_interface); end
    vectors++; if (in_full !== 1'b0) begin miscompares++; $display("FAIL reset_in_full: got %b want 0", in_full); end
    vectors++; if (core_in_data !== 32'h0) begin miscompares++; $display("FAIL reset_core_in_data: got %h want 0", core_in_data); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    // Pop while empty must be ignored.
    rd_pop = 1'b1; tick(); rd_pop = 1'b0;
    vectors++; if (empty !== 1'b1 || out_interface !== 32'h0) begin miscompares++; $display("FAIL pop_when_empty: got empty=%b out=%h want 1/0", empty, out_interface); end
  endtask

  task automatic test_single();
    core_in_ready = 1'b1;
    in_interface = 32'h0000_1234; valid_in_interface = 1'b1;
    tick();
    valid_in_interface = 1'b0;
    vectors++; if (core_in_valid !== 1'b1 || core_in_data !== 32'h0000_1234) begin miscompares++; $display("FAIL single_issue: got valid=%b data=%h want 1/00001234", core_in_valid, core_in_data); end
    tick();
    vectors++; if (core_in_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_inflight: got valid=%b busy=%b want 0/1", core_in_valid, busy); end
    tick(); tick();
    core_out_data = 32'h0ABC_0000; core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0;
    vectors++; if (valid_out_interface !== 1'b1 || out_interface !== 32'h0ABC_0000) begin miscompares++; $display("FAIL single_result: got valid=%b data=%h want 1/0abc0000", valid_out_interface, out_interface); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_clear: got %b want 0", busy); end
    rd_pop = 1'b1; tick(); rd_pop = 1'b0;
    vectors++; if (empty !== 1'b1 || valid_out_interface !== 1'b0) begin miscompares++; $display("FAIL single_pop: got empty=%b valid=%b want 1/0", empty, valid_out_interface); end
    vectors++; if (out_interface !== 32'h0ABC_0000) begin miscompares++; $display("FAIL single_hold_last: got %h want 0abc0000", out_interface); end
  endtask

  task automatic test_fill_and_credit();
    apply_reset();
    core_in_ready = 1'b0;
    valid_in_interface = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_interface = 32'hA000_0000 + 32'(i);
      tick();
      if (i == 3) begin
        vectors++; if (in_full !== 1'b1) begin miscompares++; $display("FAIL fill_full_after_4: got %b want 1", in_full); end
      end
    end
    valid_in_interface = 1'b0;
    vectors++; if (core_in_valid !== 1'b1 || core_in_data !== 32'hA000_0000) begin miscompares++; $display("FAIL fill_head_stable: got valid=%b data=%h want 1/a0000000", core_in_valid, core_in_data); end
    vectors++; if (overflow !== OVF_EN) begin miscompares++; $display("FAIL fill_overflow: got %b want %b", overflow, OVF_EN); end
    core_in_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      vectors++; if (core_in_valid !== 1'b1 || core_in_data !== 32'hA000_0000 + 32'(i)) begin miscompares++; $display("FAIL drain_order_%0d: got valid=%b data=%h want 1/%h", i, core_in_valid, core_in_data, 32'hA000_0000 + 32'(i)); end
    end
    tick();
    vectors++; if (core_in_valid !== 1'b0 || dut.inflight_q !== 3'd4) begin miscompares++; $display("FAIL drain_done: got valid=%b inflight=%0d want 0/4 (5th dropped)", core_in_valid, dut.inflight_q); end
    // Queue a 5th request while all credit is consumed.
    in_interface = 32'hA000_0005; valid_in_interface = 1'b1;
    tick();
    valid_in_interface = 1'b0;
    vectors++; if (core_in_valid !== 1'b0) begin miscompares++; $display("FAIL credit_block_inflight: got %b want 0", core_in_valid); end
    for (int i = 0; i < 4; i++) begin
      core_out_data = 32'hC000_0000 + 32'(i); core_out_valid = 1'b1;
      tick();
    end
    core_out_valid = 1'b0;
    vectors++; if (core_in_valid !== 1'b0 || dut.inflight_q !== 3'd0) begin miscompares++; $display("FAIL credit_block_outfifo: got valid=%b inflight=%0d want 0/0", core_in_valid, dut.inflight_q); end
    vectors++; if (out_interface !== 32'hC000_0000) begin miscompares++; $display("FAIL credit_out_head: got %h want c0000000", out_interface); end
    core_in_ready = 1'b0;
    rd_pop = 1'b1; tick(); rd_pop = 1'b0;
    vectors++; if (core_in_valid !== 1'b1 || core_in_data !== 32'hA000_0005) begin miscompares++; $display("FAIL credit_reassert: got valid=%b data=%h want 1/a0000005", core_in_valid, core_in_data); end
    vectors++; if (out_interface !== 32'hC000_0001) begin miscompares++; $display("FAIL credit_out_next: got %h want c0000001", out_interface); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    core_in_ready = 1'b0;
    valid_in_interface = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_interface = 32'hB000_0000 + 32'(i);
      tick();
    end
    valid_in_interface = 1'b0;
    core_in_ready = 1'b1;
    tick(); tick();
    vectors++; if (dut.inflight_q !== 3'd2 || core_in_data !== 32'hB000_0002) begin miscompares++; $display("FAIL b2b_setup: got inflight=%0d data=%h want 2/b0000002", dut.inflight_q, core_in_data); end
    core_out_data = 32'hD000_0001; core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0; core_in_ready = 1'b0;
    vectors++; if (dut.inflight_q !== 3'd2) begin miscompares++; $display("FAIL b2b_inflight: got %0d want 2", dut.inflight_q); end
    vectors++; if (dut.out_count !== 3'd1 || out_interface !== 32'hD000_0001) begin miscompares++; $display("FAIL b2b_out_count: got count=%0d data=%h want 1/d0000001", dut.out_count, out_interface); end
    vectors++; if (core_in_valid !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL b2b_state: got valid=%b busy=%b want 0/1", core_in_valid, busy); end
  endtask

  task automatic test_reset_inflight();
    // Two results are outstanding from the previous scenario.
    HRESET = 1'b1;
    #1;
    vectors++; if (dut.inflight_q !== 3'd0 || empty !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL async_reset: got inflight=%0d empty=%b busy=%b want 0/1/0", dut.inflight_q, empty, busy); end
    tick();
    HRESET = 1'b0;
    tick();
    core_out_data = 32'hEEEE_0001; core_out_valid = 1'b1;
    tick();
    core_out_valid = 1'b0;
    vectors++; if (empty !== 1'b1 || valid_out_interface !== 1'b0 || out_interface !== 32'h0) begin miscompares++; $display("FAIL stale_dropped: got empty=%b valid=%b out=%h want 1/0/0", empty, valid_out_interface, out_interface); end
    vectors++; if (dut.inflight_q !== 3'd0) begin miscompares++; $display("FAIL stale_no_underflow: got %0d want 0", dut.inflight_q); end
    vectors++; if (overflow !== OVF_EN) begin miscompares++; $display("FAIL stale_overflow: got %b want %b", overflow, OVF_EN); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_and_credit();
    test_back_to_back();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
